// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the MMIO memory access unit:
//   - size_t    : request size encodings (byte / half / word / reserved)
//   - state_t   : access sequencer states
//   - OFF_MASK_*: which byte-offset bits are meaningful for each size
//   - lane_mask / align_off / misaligned : offset helpers built on the masks
// No ports (package).
// ---------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_W    = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_ISSUE  = 3'd1,
        LD_CAP    = 3'd2,
        ST_ISSUE  = 3'd3,
        RMW_RD    = 3'd4,
        RMW_MERGE = 3'd5,
        RMW_WR    = 3'd6,
        RESP      = 3'd7
    } state_t;

    localparam int BYTE_BITS = 8;
    localparam int HALF_BITS = 16;

    // Offset bits that select a lane for each size; the cleared bits must be
    // zero for a naturally aligned access.
    localparam logic [1:0] OFF_MASK_B = 2'b11;
    localparam logic [1:0] OFF_MASK_H = 2'b10;
    localparam logic [1:0] OFF_MASK_W = 2'b00;

    function automatic logic [1:0] lane_mask(input size_t size);
        case (size)
            SIZE_B:  return OFF_MASK_B;
            SIZE_H:  return OFF_MASK_H;
            default: return OFF_MASK_W;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input size_t size, input logic [1:0] off);
        return off & lane_mask(size);
    endfunction

    function automatic logic misaligned(input size_t size, input logic [1:0] off);
        return (off & ~lane_mask(size)) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the core request/response handshake and the memory-side bus of the
// memory access unit.
//   req_*   : core -> unit load/store request (valid/ready handshake)
//   resp_*  : unit -> core response (valid/ready handshake)
//   mem_*   : unit <-> word-only memory (strobes, region, address, data)
// Modports:
//   master : environment side (core + memory) driving requests and read data
//   slave  : the access unit itself
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 16
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic                  req_ram;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    logic                  mem_load_en;
    logic                  mem_store_en;
    logic                  mem_use_ram;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output req_valid, req_store, req_ram, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_load_en, mem_store_en, mem_use_ram, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_store, req_ram, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_load_en, mem_store_en, mem_use_ram, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_lane_unit.sv
// ---------------------------------------------------------------------------
// mem_lane_unit
// Pure combinational byte-lane logic for sub-word accesses on a 32-bit word.
// Ports:
//   word       in  32  word read from memory
//   size       in  2   access size (size_t)
//   off        in  2   byte offset inside the word (already aligned to size)
//   sign_ext   in  1   sign-extend byte/half loads
//   wdata      in  32  right-aligned store data
//   load_data  out 32  addressed lane, zero/sign extended (word passes through)
//   merge_data out 32  word with the addressed lane replaced by wdata
// ---------------------------------------------------------------------------
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [BYTE_BITS-1:0] byte_sel;
    logic [HALF_BITS-1:0] half_sel;

    always_comb begin
        byte_sel  = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel  = off[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (size)
            SIZE_B:  load_data = {{(32-BYTE_BITS){sign_ext & byte_sel[BYTE_BITS-1]}}, byte_sel};
            SIZE_H:  load_data = {{(32-HALF_BITS){sign_ext & half_sel[HALF_BITS-1]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane takes store data; every other lane keeps the
    // value that was just read back.
    always_comb begin
        merge_data = word;
        case (size)
            SIZE_B: begin
                case (off)
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    2'd3:    merge_data[31:24] = wdata[7:0];
                    default: merge_data[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_H: begin
                if (off[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0]  = wdata[15:0];
                end
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the MMIO memory port. Takes byte/half/word load and store
// requests from the core, sequences the word-only memory (sub-word stores are
// done as read-modify-write), extracts/extends sub-word load data and returns
// a single response per request.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    mem_access_unit_if.slave : req_*, resp_*, mem_* signals
// Configuration:
//   MEM_ACCESS_ERR_EN defined   : reserved size, misaligned half/word and
//                                 ROM stores complete with resp_err=1 and no
//                                 memory traffic.
//   MEM_ACCESS_ERR_EN undefined : resp_err is 0, misaligned offsets are
//                                 cleared down to the size, reserved size
//                                 acts as word, ROM stores run normally with
//                                 mem_use_ram=0.
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input logic             clk,
    input logic             reset,
    mem_access_unit_if.slave bus
);

    state_t                state;
    state_t                state_next;

    size_t                 lat_size;
    logic [1:0]            lat_off;
    logic                  lat_signed;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  use_ram_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    logic                  accept;
    size_t                 req_size_in;
    size_t                 eff_size;
    logic [1:0]            eff_off;
    logic                  req_fault;

    logic [31:0]           load_data;
    logic [31:0]           merge_data;

    assign accept      = bus.req_valid && (state == IDLE);
    assign req_size_in = size_t'(bus.req_size);

    // Request decode: either flag faults, or normalise size/offset so that
    // every request maps onto a legal aligned access.
    always_comb begin
        eff_size  = req_size_in;
        eff_off   = bus.req_addr[1:0];
        req_fault = 1'b0;
`ifdef MEM_ACCESS_ERR_EN
        req_fault = (req_size_in == SIZE_RSVD)
                 || misaligned(req_size_in, bus.req_addr[1:0])
                 || (bus.req_store && !bus.req_ram);
`else
        if (req_size_in == SIZE_RSVD) begin
            eff_size = SIZE_W;
        end
        eff_off = align_off(eff_size, bus.req_addr[1:0]);
`endif
    end

    // lat_size/lat_off/wdata_q describe the in-flight access. wdata_q doubles
    // as the store data source for the merge and as the merged result driven
    // on mem_wdata during RMW_WR.
    mem_lane_unit u_lane (
        .word       (bus.mem_rdata),
        .size       (lat_size),
        .off        (lat_off),
        .sign_ext   (lat_signed),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_next = RESP;
                    end else if (!bus.req_store) begin
                        state_next = LD_ISSUE;
                    end else if (eff_size == SIZE_W) begin
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LD_ISSUE:  state_next = LD_CAP;
            LD_CAP:    state_next = RESP;
            ST_ISSUE:  state_next = RESP;
            RMW_RD:    state_next = RMW_MERGE;
            RMW_MERGE: state_next = RMW_WR;
            RMW_WR:    state_next = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Datapath registers. The read word arrives the cycle after the load
    // strobe, so both the load capture and the RMW merge happen one state
    // after their issue state. Response data is cleared once consumed so a
    // stale load result never lingers while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_size   <= SIZE_B;
            lat_off    <= 2'b00;
            lat_signed <= 1'b0;
            addr_q     <= '0;
            use_ram_q  <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_size   <= eff_size;
                        lat_off    <= eff_off;
                        lat_signed <= bus.req_signed;
                        addr_q     <= bus.req_addr[ADDR_WIDTH+1:2];
                        use_ram_q  <= bus.req_ram;
                        wdata_q    <= bus.req_wdata;
                        rdata_q    <= '0;
                    end
                end
                LD_CAP:    rdata_q <= load_data;
                RMW_MERGE: wdata_q <= merge_data;
                RESP: begin
                    if (bus.resp_ready) begin
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_ERR_EN
    logic err_q;

    // Fault flag is captured with the request and dropped when the response
    // is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_fault;
        end else if ((state == RESP) && bus.resp_ready) begin
            err_q <= 1'b0;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_rdata   = rdata_q;
    assign bus.mem_load_en  = (state == LD_ISSUE) || (state == RMW_RD);
    assign bus.mem_store_en = (state == ST_ISSUE) || (state == RMW_WR);
    assign bus.mem_use_ram  = use_ram_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. A behavioural word memory (RAM and
// ROM, registered read) sits on the mem_* side; a reference model computes
// each access's expected result, latency, strobes and RAM contents from plain
// shift/mask arithmetic. Follows MEM_ACCESS_ERR_EN the same way the design
// does.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int AW = 16;

    logic clk;
    logic reset;
    logic init_mem;

    int tests;
    int fails;

    logic [31:0] tb_ram  [0:65535];
    logic [31:0] ref_ram [0:65535];
    logic [31:0] rom     [0:65535];

    mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: registered read one cycle after the load strobe, RAM writes on
    // the store strobe, ROM ignores writes. Also seeds RAM once at start.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 65536; i++) begin
                tb_ram[i] <= $urandom;
            end
            tb_ram[1] <= 32'h80FF7F01;
            tb_ram[2] <= 32'h11223344;
        end else begin
            if (bus.mem_load_en) begin
                bus.mem_rdata <= bus.mem_use_ram ? tb_ram[bus.mem_addr] : rom[bus.mem_addr];
            end
            if (bus.mem_store_en && bus.mem_use_ram) begin
                tb_ram[bus.mem_addr] <= bus.mem_wdata;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model of one access; updates ref_ram for successful RAM stores.
    task automatic ref_access(input bit store, input bit ram, input bit [1:0] size,
                              input bit sgn, input bit [17:0] addr, input bit [31:0] wdata,
                              output bit [31:0] rdata, output bit err, output int lat,
                              output int nld, output int nst, output bit [31:0] st_word);
        int esz;
        int off;
        bit [15:0] widx;
        bit [31:0] mask;
        bit [31:0] word;
        bit [31:0] val;
        widx    = addr[17:2];
        off     = int'(addr[1:0]);
        esz     = int'(size);
        rdata   = 0;
        nld     = 0;
        nst     = 0;
        st_word = 0;
        lat     = 0;
`ifdef MEM_ACCESS_ERR_EN
        err = (esz == 3) || (esz == 1 && off % 2 != 0) || (esz == 2 && off != 0) || (store && !ram);
`else
        err = 0;
        if (esz == 3) esz = 2;
        off = off - (off % (1 << esz));
`endif
        if (err) begin
            lat = 1;
            return;
        end
        mask = (esz == 2) ? 32'hFFFFFFFF : ((32'd1 << (8 << esz)) - 32'd1);
        word = ram ? ref_ram[widx] : rom[widx];
        if (!store) begin
            val = (word >> (8 * off)) & mask;
            if (sgn && esz < 2 && ((val >> ((8 << esz) - 1)) & 32'd1) == 32'd1) val = val | ~mask;
            rdata = val;
            lat   = 3;
            nld   = 1;
        end else if (esz == 2) begin
            st_word = wdata;
            lat     = 2;
            nst     = 1;
        end else begin
            st_word = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            lat     = 4;
            nld     = 1;
            nst     = 1;
        end
        if (store && ram) ref_ram[widx] = st_word;
    endtask

    // One complete access from an idle negedge to the negedge after the
    // response handshake. hold = cycles resp_ready stays low in RESP, during
    // which a stray request is presented and must be ignored.
    task automatic do_access(input string tag, input bit store, input bit ram, input bit [1:0] size,
                             input bit sgn, input bit [17:0] addr, input bit [31:0] wdata, input int hold);
        bit [31:0] exp_rdata;
        bit [31:0] exp_wword;
        bit        exp_err;
        int        exp_lat;
        int        exp_nld;
        int        exp_nst;
        int        k;
        int        nld;
        int        nst;
        int        ld_at;
        int        st_at;
        bit [15:0] ld_addr;
        bit [15:0] st_addr;
        bit [31:0] st_data;
        bit        got;
        bit [15:0] widx;
        widx = addr[17:2];
        ref_access(store, ram, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat, exp_nld, exp_nst, exp_wword);

        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s idle_ready: got %b expected 1", tag, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_ram    = ram;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1; got = 0; nld = 0; nst = 0; ld_at = 0; st_at = 0;
        ld_addr = 0; st_addr = 0; st_data = 0;
        while (k <= 12 && !got) begin
            if (bus.mem_load_en === 1'b1) begin
                nld++; ld_at = k; ld_addr = bus.mem_addr;
            end
            if (bus.mem_store_en === 1'b1) begin
                nst++; st_at = k; st_addr = bus.mem_addr; st_data = bus.mem_wdata;
            end
            if (bus.resp_valid === 1'b1) got = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end

        tests++;
        if (!got) begin
            fails++;
            $display("[TB] FAIL %s resp_timeout: got no resp_valid expected at cycle %0d", tag, exp_lat);
        end
        tests++;
        if (k != exp_lat) begin
            fails++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", tag, k, exp_lat);
        end
        tests++;
        if (bus.resp_rdata !== exp_rdata) begin
            fails++;
            $display("[TB] FAIL %s rdata: got %h expected %h", tag, bus.resp_rdata, exp_rdata);
        end
        tests++;
        if (bus.resp_err !== exp_err) begin
            fails++;
            $display("[TB] FAIL %s err: got %b expected %b", tag, bus.resp_err, exp_err);
        end
        tests++;
        if (nld != exp_nld || nst != exp_nst) begin
            fails++;
            $display("[TB] FAIL %s strobe_count: got ld=%0d st=%0d expected ld=%0d st=%0d",
                     tag, nld, nst, exp_nld, exp_nst);
        end
        if (exp_nld == 1) begin
            tests++;
            if (ld_at != 1 || ld_addr != widx) begin
                fails++;
                $display("[TB] FAIL %s load_strobe: got cycle %0d addr %h expected cycle 1 addr %h",
                         tag, ld_at, ld_addr, widx);
            end
        end
        if (exp_nst == 1) begin
            tests++;
            if (st_at != exp_lat - 1 || st_addr != widx || st_data !== exp_wword) begin
                fails++;
                $display("[TB] FAIL %s store_strobe: got cycle %0d addr %h data %h expected cycle %0d addr %h data %h",
                         tag, st_at, st_addr, st_data, exp_lat - 1, widx, exp_wword);
            end
        end

        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_store = 1'b0;
            bus.req_size  = 2'b10;
            bus.req_addr  = 18'h00010;
            @(negedge clk);
            tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_rdata || bus.resp_err !== exp_err
                || bus.req_ready !== 1'b0 || bus.mem_load_en !== 1'b0 || bus.mem_store_en !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b ld=%b st=%b expected 1 %h %b 0 0 0",
                         tag, h, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready,
                         bus.mem_load_en, bus.mem_store_en, exp_rdata, exp_err);
            end
        end

        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s release: got ready=%b valid=%b expected ready=1 valid=0",
                     tag, bus.req_ready, bus.resp_valid);
        end
        if (store && ram) begin
            tests++;
            if (tb_ram[widx] !== ref_ram[widx]) begin
                fails++;
                $display("[TB] FAIL %s ram_word: got %h expected %h", tag, tb_ram[widx], ref_ram[widx]);
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_handshake: got ready=%b valid=%b err=%b expected 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err);
        end
        tests++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_addr !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: got rdata=%h wdata=%h addr=%h expected all 0",
                     bus.resp_rdata, bus.mem_wdata, bus.mem_addr);
        end
        tests++;
        if (bus.mem_load_en !== 1'b0 || bus.mem_store_en !== 1'b0 || bus.mem_use_ram !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes: got ld=%b st=%b ram=%b expected 0 0 0",
                     bus.mem_load_en, bus.mem_store_en, bus.mem_use_ram);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        do_access("word_load", 1'b0, 1'b0, 2'b10, 1'b0, 18'h0000C, 32'h0, 0);
    endtask

    task automatic test_signed_byte();
        do_access("byte_signed", 1'b0, 1'b1, 2'b00, 1'b1, 18'h00007, 32'h0, 0);
        do_access("byte_unsigned", 1'b0, 1'b1, 2'b00, 1'b0, 18'h00007, 32'h0, 0);
        do_access("half_signed", 1'b0, 1'b1, 2'b01, 1'b1, 18'h00006, 32'h0, 0);
    endtask

    task automatic test_byte_store();
        do_access("byte_store", 1'b1, 1'b1, 2'b00, 1'b0, 18'h00009, 32'h000000AB, 0);
        do_access("byte_readback", 1'b0, 1'b1, 2'b10, 1'b0, 18'h00008, 32'h0, 0);
        do_access("word_store", 1'b1, 1'b1, 2'b10, 1'b0, 18'h00010, 32'hCAFEF00D, 0);
    endtask

    task automatic test_errors();
        do_access("rom_store", 1'b1, 1'b0, 2'b10, 1'b0, 18'h00010, 32'h12345678, 0);
        do_access("half_misaligned", 1'b0, 1'b1, 2'b01, 1'b0, 18'h00003, 32'h0, 0);
        do_access("size_reserved", 1'b0, 1'b1, 2'b11, 1'b0, 18'h00004, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        do_access("backpressure", 1'b0, 1'b0, 2'b10, 1'b0, 18'h0000C, 32'h0, 5);
    endtask

    task automatic test_reset_mid_rmw();
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_ram    = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 18'h00015;
        bus.req_wdata  = 32'h000000EE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests++;
        if (bus.mem_load_en !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_rmw_read: got ld=%b expected 1", bus.mem_load_en);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_store_en !== 1'b0
            || bus.mem_load_en !== 1'b0 || bus.mem_wdata !== 32'h0 || bus.mem_addr !== 16'h0
            || bus.mem_use_ram !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL rst_rmw_outputs: got ready=%b valid=%b st=%b ld=%b wdata=%h addr=%h ram=%b rdata=%h expected reset values",
                     bus.req_ready, bus.resp_valid, bus.mem_store_en, bus.mem_load_en,
                     bus.mem_wdata, bus.mem_addr, bus.mem_use_ram, bus.resp_rdata);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_store_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rst_rmw_quiet%0d: got st=%b valid=%b expected 0 0",
                         i, bus.mem_store_en, bus.resp_valid);
            end
        end
        tests++;
        if (tb_ram[5] !== ref_ram[5]) begin
            fails++;
            $display("[TB] FAIL rst_rmw_ram: got %h expected %h", tb_ram[5], ref_ram[5]);
        end
    endtask

    task automatic test_random();
        bit [15:0] widx;
        bit [17:0] addr;
        for (int n = 0; n < 60; n++) begin
            widx = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(16'hFFF8, 16'hFFFF));
            addr = {widx, 2'($urandom_range(0, 3))};
            do_access($sformatf("rand%0d", n), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                      2'($urandom), 1'($urandom), addr, $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        do_access("b2b_a", 1'b0, 1'b1, 2'b10, 1'b0, 18'h00004, 32'h0, 0);
        do_access("b2b_b", 1'b1, 1'b1, 2'b01, 1'b0, 18'h00006, 32'h0000BEEF, 0);
        do_access("b2b_c", 1'b0, 1'b1, 2'b01, 1'b1, 18'h00006, 32'h0, 0);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        clk            = 1'b0;
        reset          = 1'b1;
        init_mem       = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_ram    = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            rom[i] = $urandom;
        end
        rom[3] = 32'hDEADBEEF;
        @(negedge clk);
        init_mem = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 65536; i++) begin
            ref_ram[i] = tb_ram[i];
        end

        test_reset();
        test_word_load();
        test_signed_byte();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the on-chip MMIO memory port: accepts load/store requests from the VM core and drives the memory's load/store strobes, region select, word address and write data.
- Captures the registered read data and returns it to the core.
- Adds byte/halfword access on top of the word-only memory: lane extract plus sign/zero extension on loads, read-modify-write on sub-word stores.
- Detects misaligned accesses and stores to ROM.

Parameters:
- ADDR_WIDTH, 16, word-address width driven to memory; request byte address is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_store  in  1  1 = store, 0 = load
- req_ram  in  1  region: 1 = RAM, 0 = ROM
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  core consumes response
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  access fault
- mem_load_en  out  1  memory read strobe
- mem_store_en  out  1  memory write strobe
- mem_use_ram  out  1  memory region select
- mem_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_load_en

Behaviour:
- Reset: state IDLE.
  - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_load_en=0, mem_store_en=0, mem_use_ram=0, mem_addr=0, mem_wdata=0.
- Request latching: the request is latched on acceptance (cycle T). req_ready=1 only in IDLE; req_valid in any other state is ignored.
- FSM states: IDLE, LD_ISSUE, LD_CAP, ST_ISSUE, RMW_RD, RMW_MERGE, RMW_WR, RESP.
- Strobes: mem_* outputs are driven from latched registers.
  - mem_load_en=1 only in LD_ISSUE and RMW_RD.
  - mem_store_en=1 only in ST_ISSUE and RMW_WR.
  - Each strobe is exactly one cycle per access.
- Word or sub-word load: IDLE -> LD_ISSUE (T+1) -> LD_CAP (T+2, sample mem_rdata) -> RESP (resp_valid at T+3).
- Word store: IDLE -> ST_ISSUE (T+1, mem_wdata=req_wdata) -> RESP (T+2).
- Byte/half store: IDLE -> RMW_RD (T+1) -> RMW_MERGE (T+2, merge into captured word) -> RMW_WR (T+3) -> RESP (T+4).
- Lane extract:
  - Byte = bits [8*off+7:8*off], off = req_addr[1:0].
  - Half = bits [16*off[1]+15:16*off[1]].
  - Zero-extended unless req_signed. Sign extension is ignored for word loads.
- Merge: replace only the addressed lane with the low bits of req_wdata. Other lanes keep the read value.
- Errors (resp_err=1):
  - size 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - store with req_ram=0.
  - On any error: IDLE -> RESP at T+1, no memory strobe, resp_rdata=0.
- Response handshake: RESP holds resp_valid and resp_rdata/resp_err stable until resp_valid & resp_ready, then returns to IDLE. The next request is accepted no earlier than the following cycle.
- Wrap-around: mem_addr is truncated to ADDR_WIDTH bits; no carry, no bounds check.
- Reset mid-operation: abort immediately to reset values.
  - An RMW interrupted before RMW_WR performs no write.
  - A pending response is discarded.

Optional Feature:
- Macro: MEM_ACCESS_ERR_EN.
- Defined: error detection as above.
- Undefined:
  - resp_err tied 0.
  - Misaligned addresses are forced aligned (low offset bits cleared per size).
  - Size 11 is treated as word.
  - ROM stores still traverse ST_ISSUE/RMW_WR with mem_use_ram=0, which the memory ignores. Response timing is unchanged.

Decomposition:
- Package mem_access_pkg:
  - size encodings (SIZE_B/SIZE_H/SIZE_W);
  - FSM state enum;
  - lane-offset constants.
- Sub-module mem_lane_unit: pure-combinational lane extract/extend and lane merge, shared by load capture and RMW merge.

Test Plan:
- Word load: ROM[3]=0xDEADBEEF, load ram=0 addr=0x000C size=10 -> mem_load_en once at T+1, mem_addr=3; resp_rdata=0xDEADBEEF at T+3, err=0.
- Signed byte load: RAM[1]=0x80FF7F01, addr=0x0007 byte signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Byte store RMW: RAM[2]=0x11223344, store byte 0xAB at addr=0x0009 -> load strobe T+1, store strobe T+3 with mem_wdata=0x1122AB44; resp at T+4.
- Errors: store to ROM, or half load at addr=0x0003 -> resp_err=1 at T+1, no mem strobes. With macro off, the half load returns the half at offset 2.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
- Reset in RMW_MERGE -> no mem_store_en ever, RAM unchanged, all outputs at reset values next cycle.
